// File: rtl/arm_cpu_if.sv
// Purpose : bundles the core's fetch, register-file and data-memory signals.
// Latency : none, wires only.
// Backpressure: none. The memories and register file are combinational reads.
// Ports   : master = core side (drives PC, control, register indices, ALU result);
//           slave  = instruction memory / register file / data memory side.
interface arm_cpu_if;
    logic [31:0] INSTRUCTION;
    logic [63:0] PC;
    logic        CONTROL_REG2LOC;
    logic        CONTROL_REGWRITE;
    logic        CONTROL_MEMREAD;
    logic        CONTROL_MEMWRITE;
    logic        CONTROL_BRANCH;
    logic [4:0]  READ_REG_1;
    logic [4:0]  READ_REG_2;
    logic [4:0]  WRITE_REG;
    logic [63:0] REG_DATA1;
    logic [63:0] REG_DATA2;
    logic [63:0] ALU_Result_Out;
    logic [63:0] data_memory_out;
    logic [63:0] WRITE_REG_DATA;

    modport master (
        input  INSTRUCTION, REG_DATA1, REG_DATA2, data_memory_out,
        output PC, CONTROL_REG2LOC, CONTROL_REGWRITE, CONTROL_MEMREAD,
               CONTROL_MEMWRITE, CONTROL_BRANCH, READ_REG_1, READ_REG_2,
               WRITE_REG, ALU_Result_Out, WRITE_REG_DATA
    );

    modport slave (
        output INSTRUCTION, REG_DATA1, REG_DATA2, data_memory_out,
        input  PC, CONTROL_REG2LOC, CONTROL_REGWRITE, CONTROL_MEMREAD,
               CONTROL_MEMWRITE, CONTROL_BRANCH, READ_REG_1, READ_REG_2,
               WRITE_REG, ALU_Result_Out, WRITE_REG_DATA
    );
endinterface

// File: rtl/arm_cpu.sv
// Purpose : single-cycle LEGv8 core (PC, decoder, ALU, sign-extend, branch).
// Latency : decode/ALU combinational; PC advances once per CLOCK rising edge.
// Backpressure: none. One instruction retires every cycle.
// Ports   : CLOCK, RESET_N (async active-low); bus = arm_cpu_if.master.
module arm_cpu (
    input  logic        CLOCK,
    input logic         RESET_N,
    arm_cpu_if.master   bus
);
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [5:0]  OP_B    = 6'b000101;

    typedef enum logic [2:0] {
        ALU_ZERO,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_ORR,
        ALU_PASSB
    } alu_op_e;

    logic [31:0] instr;
    logic [63:0] pc_q, pc_d;

    logic        reg2loc, regwrite, memread, memwrite, branch, mem_to_reg;
    logic        uncond;
    logic        use_imm;
    alu_op_e     alu_op;

    logic [63:0] imm9_sext;
    logic [63:0] cbz_off;
    logic [63:0] b_off;
    logic [63:0] alu_b;
    logic [63:0] alu_res;
    logic        alu_zero;

    assign instr = bus.INSTRUCTION;

    // Immediates: D-format offset is a byte offset, branch offsets are word offsets.
    assign imm9_sext = {{55{instr[20]}}, instr[20:12]};
    assign cbz_off   = {{43{instr[23]}}, instr[23:5], 2'b00};
    assign b_off     = {{36{instr[25]}}, instr[25:0], 2'b00};

    // Main decoder
    always_comb begin
        reg2loc    = 1'b0;
        regwrite   = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        branch     = 1'b0;
        mem_to_reg = 1'b0;
        uncond     = 1'b0;
        use_imm    = 1'b0;
        alu_op     = ALU_ZERO;
        if (instr[31:21] == OP_ADD) begin
            alu_op   = ALU_ADD;
            regwrite = 1'b1;
        end else if (instr[31:21] == OP_SUB) begin
            alu_op   = ALU_SUB;
            regwrite = 1'b1;
        end else if (instr[31:21] == OP_AND) begin
            alu_op   = ALU_AND;
            regwrite = 1'b1;
        end else if (instr[31:21] == OP_ORR) begin
            alu_op   = ALU_ORR;
            regwrite = 1'b1;
        end else if (instr[31:21] == OP_LDUR) begin
            alu_op     = ALU_ADD;
            use_imm    = 1'b1;
            memread    = 1'b1;
            mem_to_reg = 1'b1;
            regwrite   = 1'b1;
        end else if (instr[31:21] == OP_STUR) begin
            alu_op   = ALU_ADD;
            use_imm  = 1'b1;
            reg2loc  = 1'b1;
            memwrite = 1'b1;
        end else if (instr[31:24] == OP_CBZ) begin
            alu_op  = ALU_PASSB;
            reg2loc = 1'b1;
            branch  = 1'b1;
        end else if (instr[31:26] == OP_B) begin
            uncond = 1'b1;
        end
    end

    // ALU
    assign alu_b = use_imm ? imm9_sext : bus.REG_DATA2;

    always_comb begin
        alu_res = 64'd0;
        unique case (alu_op)
            ALU_ADD:   alu_res = bus.REG_DATA1 + alu_b;
            ALU_SUB:   alu_res = bus.REG_DATA1 - alu_b;
            ALU_AND:   alu_res = bus.REG_DATA1 & alu_b;
            ALU_ORR:   alu_res = bus.REG_DATA1 | alu_b;
            ALU_PASSB: alu_res = alu_b;
            default:   alu_res = 64'd0;
        endcase
    end

    assign alu_zero = (alu_res == 64'd0);

    // Next PC
    always_comb begin
        pc_d = pc_q + 64'd4;
        if (uncond)
            pc_d = pc_q + b_off;
        else if (branch && alu_zero)
            pc_d = pc_q + cbz_off;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)
            pc_q <= 64'd0;
        else
            pc_q <= pc_d;
    end

    // Outputs. Side-effecting enables are held low in reset, and writes to
    // X31 (XZR) are suppressed here so the register file need not special-case it.
    assign bus.PC               = pc_q;
    assign bus.CONTROL_REG2LOC  = reg2loc;
    assign bus.CONTROL_REGWRITE = RESET_N & regwrite & (instr[4:0] != 5'd31);
    assign bus.CONTROL_MEMREAD  = RESET_N & memread;
    assign bus.CONTROL_MEMWRITE = RESET_N & memwrite;
    assign bus.CONTROL_BRANCH   = RESET_N & branch;
    assign bus.READ_REG_1       = instr[9:5];
    assign bus.READ_REG_2       = reg2loc ? instr[4:0] : instr[20:16];
    assign bus.WRITE_REG        = instr[4:0];
    assign bus.ALU_Result_Out   = alu_res;
    assign bus.WRITE_REG_DATA   = mem_to_reg ? bus.data_memory_out : alu_res;
endmodule

// File: tb/tb_arm_cpu.sv
// Purpose : directed, table-driven bench for arm_cpu plus reset/branch sequences.
// Latency : n/a.
// Backpressure: n/a.
module tb_arm_cpu;
    logic CLOCK;
    logic RESET_N;

    arm_cpu_if bus ();

    arm_cpu dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus.master)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    localparam logic [31:0] I_ADD  = 32'h8B020023;
    localparam logic [31:0] I_LDUR = 32'hF8408142;
    localparam logic [31:0] I_STUR = 32'hF8000142;
    localparam logic [31:0] I_CBZ  = 32'hB4000065;
    localparam logic [31:0] I_B    = 32'h17FFFFFE;
    localparam logic [31:0] I_NOP  = 32'h00000000;

    // ctl = {reg2loc, regwrite, memread, memwrite, branch}
    typedef struct {
        logic [31:0] instr;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] dmem;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  wr;
        logic [4:0]  ctl;
        logic [63:0] pc_delta;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_pc;
    vec_t vecs[15];

    function automatic vec_t mk(input logic [31:0] instr, input logic [63:0] rd1,
                                input logic [63:0] rd2, input logic [63:0] dmem,
                                input logic [63:0] alu, input logic [63:0] wdata,
                                input logic [4:0] rr1, input logic [4:0] rr2,
                                input logic [4:0] wr, input logic [4:0] ctl,
                                input logic [63:0] pc_delta);
        vec_t v;
        v.instr = instr; v.rd1 = rd1; v.rd2 = rd2; v.dmem = dmem;
        v.alu = alu; v.wdata = wdata; v.rr1 = rr1; v.rr2 = rr2;
        v.wr = wr; v.ctl = ctl; v.pc_delta = pc_delta;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ctl_now();
        return {bus.CONTROL_REG2LOC, bus.CONTROL_REGWRITE, bus.CONTROL_MEMREAD,
                bus.CONTROL_MEMWRITE, bus.CONTROL_BRANCH};
    endfunction

    // Pulse reset, release on a falling edge, then run n NOP cycles (PC ends at 4*n).
    task automatic reset_and_run(input int n);
        RESET_N = 1'b0;
        bus.INSTRUCTION = I_NOP;
        #1;
        @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(I_ADD, 64'd5, 64'd7, 64'd0, 64'd12, 64'd12, 5'd1, 5'd2, 5'd3, 5'b01000, 64'd4);
        vecs[1]  = mk(32'hCB020023, 64'd5, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE,
                      64'hFFFF_FFFF_FFFF_FFFE, 5'd1, 5'd2, 5'd3, 5'b01000, 64'd4);
        vecs[2]  = mk(32'h8A020023, 64'hF0F0, 64'hFF00, 64'd0, 64'hF000, 64'hF000,
                      5'd1, 5'd2, 5'd3, 5'b01000, 64'd4);
        vecs[3]  = mk(32'hAA020023, 64'hF0F0, 64'hFF00, 64'd0, 64'hFFF0, 64'hFFF0,
                      5'd1, 5'd2, 5'd3, 5'b01000, 64'd4);
        vecs[4]  = mk(I_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 64'd0,
                      5'd1, 5'd2, 5'd3, 5'b01000, 64'd4);
        vecs[5]  = mk(I_LDUR, 64'h100, 64'd9, 64'hDEAD, 64'h108, 64'hDEAD,
                      5'd10, 5'd0, 5'd2, 5'b01100, 64'd4);
        vecs[6]  = mk(32'hF85F8142, 64'h100, 64'd9, 64'hBEEF, 64'hF8, 64'hBEEF,
                      5'd10, 5'd31, 5'd2, 5'b01100, 64'd4);
        vecs[7]  = mk(I_STUR, 64'h200, 64'h55, 64'hAAAA, 64'h200, 64'h200,
                      5'd10, 5'd2, 5'd2, 5'b10010, 64'd4);
        vecs[8]  = mk(32'h8B02003F, 64'd5, 64'd7, 64'd0, 64'd12, 64'd12,
                      5'd1, 5'd2, 5'd31, 5'b00000, 64'd4);
        vecs[9]  = mk(I_NOP, 64'd3, 64'd4, 64'h77, 64'd0, 64'd0,
                      5'd0, 5'd0, 5'd0, 5'b00000, 64'd4);
        vecs[10] = mk(I_B, 64'd3, 64'd4, 64'd0, 64'd0, 64'd0,
                      5'd31, 5'd31, 5'd30, 5'b00000, 64'hFFFF_FFFF_FFFF_FFF8);
        vecs[11] = mk(I_CBZ, 64'd99, 64'd0, 64'd0, 64'd0, 64'd0,
                      5'd3, 5'd5, 5'd5, 5'b10001, 64'd12);
        vecs[12] = mk(I_CBZ, 64'd99, 64'd1, 64'd0, 64'd1, 64'd1,
                      5'd3, 5'd5, 5'd5, 5'b10001, 64'd4);
        vecs[13] = mk(32'hB4FFFFE5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                      5'd31, 5'd5, 5'd5, 5'b10001, 64'hFFFF_FFFF_FFFF_FFFC);
        vecs[14] = mk(I_CBZ, 64'd0, 64'h8000_0000_0000_0000, 64'd0,
                      64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                      5'd3, 5'd5, 5'd5, 5'b10001, 64'd4);

        // Reset state: PC cleared and enables forced low even with a writing instruction.
        RESET_N = 1'b0;
        bus.INSTRUCTION = I_ADD;
        bus.REG_DATA1 = 64'd5;
        bus.REG_DATA2 = 64'd7;
        bus.data_memory_out = 64'd0;
        #2;
        chk("rst_pc", bus.PC, 64'd0);
        chk("rst_ctl_add", {59'd0, ctl_now()}, 64'd0);
        bus.INSTRUCTION = I_CBZ;
        bus.REG_DATA2 = 64'd0;
        #1;
        chk("rst_ctl_cbz", {59'd0, ctl_now()}, 64'b10000);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        bus.INSTRUCTION = I_NOP;
        #1;
        chk("rel_pc", bus.PC, 64'd0);
        @(posedge CLOCK);
        #1;
        chk("first_fetch", bus.PC, 64'd4);
        exp_pc = 64'd4;

        for (int i = 0; i < 15; i++) begin
            bus.INSTRUCTION     = vecs[i].instr;
            bus.REG_DATA1       = vecs[i].rd1;
            bus.REG_DATA2       = vecs[i].rd2;
            bus.data_memory_out = vecs[i].dmem;
            #2;
            chk($sformatf("v%0d_alu", i), bus.ALU_Result_Out, vecs[i].alu);
            chk($sformatf("v%0d_wdata", i), bus.WRITE_REG_DATA, vecs[i].wdata);
            chk($sformatf("v%0d_regs", i), {49'd0, bus.READ_REG_1, bus.READ_REG_2, bus.WRITE_REG},
                {49'd0, vecs[i].rr1, vecs[i].rr2, vecs[i].wr});
            chk($sformatf("v%0d_ctl", i), {59'd0, ctl_now()}, {59'd0, vecs[i].ctl});
            exp_pc = exp_pc + vecs[i].pc_delta;
            @(posedge CLOCK);
            #1;
            chk($sformatf("v%0d_pc", i), bus.PC, exp_pc);
        end

        // Asynchronous reset mid-run at PC=0x20.
        reset_and_run(8);
        chk("mid_pc_before", bus.PC, 64'h20);
        bus.INSTRUCTION = I_ADD;
        #1;
        chk("mid_regwrite_on", {63'd0, bus.CONTROL_REGWRITE}, 64'd1);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_pc", bus.PC, 64'd0);
        chk("mid_rst_regwrite", {63'd0, bus.CONTROL_REGWRITE}, 64'd0);
        bus.INSTRUCTION = I_STUR;
        #1;
        chk("mid_rst_memwrite", {63'd0, bus.CONTROL_MEMWRITE}, 64'd0);
        bus.INSTRUCTION = I_LDUR;
        #1;
        chk("mid_rst_memread", {63'd0, bus.CONTROL_MEMREAD}, 64'd0);
        @(posedge CLOCK);
        #1;
        chk("mid_rst_hold", bus.PC, 64'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        bus.INSTRUCTION = I_NOP;
        #1;
        chk("mid_rel_pc", bus.PC, 64'd0);
        @(posedge CLOCK);
        #1;
        chk("mid_refetch", bus.PC, 64'd4);

        // CBZ at PC=0x10, taken and not taken.
        reset_and_run(4);
        chk("cbz_at", bus.PC, 64'h10);
        bus.INSTRUCTION = I_CBZ;
        bus.REG_DATA2 = 64'd0;
        @(posedge CLOCK);
        #1;
        chk("cbz_taken", bus.PC, 64'h1C);
        reset_and_run(4);
        bus.INSTRUCTION = I_CBZ;
        bus.REG_DATA2 = 64'd1;
        @(posedge CLOCK);
        #1;
        chk("cbz_not_taken", bus.PC, 64'h14);

        // B backwards from 0x20, then illegal encoding as NOP.
        reset_and_run(8);
        bus.INSTRUCTION = I_B;
        @(posedge CLOCK);
        #1;
        chk("b_target", bus.PC, 64'h18);
        bus.INSTRUCTION = I_NOP;
        bus.REG_DATA1 = 64'h1234;
        bus.REG_DATA2 = 64'h5678;
        #1;
        chk("nop_alu", bus.ALU_Result_Out, 64'd0);
        @(posedge CLOCK);
        #1;
        chk("nop_pc", bus.PC, 64'h1C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
